tut4_verilog_gcd_gcd_client: RTL and testbench

TUT4_VERILOG_GCD_GCD_CLIENT -- requirements
Module: tut4_verilog_gcd_GcdClient

---
 rtl/tut4_verilog_gcd_gcd_client_if.sv | 40 ++++
 rtl/tut4_verilog_gcd_gcd_client.sv | 206 ++++++++++++++++++++
 tb/tb_tut4_verilog_gcd_gcd_client.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tut4_verilog_gcd_gcd_client_if.sv
// ---------------------------------------------------------------------------
// tut4_verilog_gcd_gcd_client_if
//
// One val/rdy channel. A transfer happens in any cycle where val and rdy
// are both high. The client uses four of these: cmd (40 bits), req (32 bits),
// resp (16 bits) and done (24 bits).
//
// Parameters:
//   W   width of the message carried on the channel
//
// Signals:
//   val  producer -> consumer  message valid
//   rdy  consumer -> producer  consumer can take the message
//   msg  producer -> consumer  payload, meaningful while val is high
//
// Modports:
//   master  producer side (drives val/msg, observes rdy)
//   slave   consumer side (observes val/msg, drives rdy)
// ---------------------------------------------------------------------------
interface tut4_verilog_gcd_gcd_client_if #(
  parameter int W = 32
) ();

  logic         val;
  logic         rdy;
  logic [W-1:0] msg;

  modport master (
    output val,
    output msg,
    input  rdy
  );

  modport slave (
    input  val,
    input  msg,
    output rdy
  );

endinterface

// File: rtl/tut4_verilog_gcd_gcd_client.sv
// ---------------------------------------------------------------------------
// tut4_verilog_gcd_gcd_client
//
// Drives a stream of GCD requests to a GCD unit and reports a summary.
// A command carries a count N, a base operand a0 and a fixed operand b0.
// The client then issues N requests {a0+i, b0} (i = 0..N-1, a wrapping
// mod 2^16), keeps at most p_max_out of them outstanding, accumulates the
// returned results mod 2^16, and finally presents {responses, sum} on the
// done channel until it is accepted.
//
// Parameters:
//   p_max_out  maximum requests in flight, 1..4
//
// Ports:
//   clk    clock, rising edge
//   reset  asynchronous reset, active low
//   cmd    slave,  40 bits: [39:32] N, [31:16] a0, [15:0] b0
//   req    master, 32 bits: [31:16] a, [15:0] b
//   resp   slave,  16 bits: GCD result
//   done   master, 24 bits: [23:16] responses received, [15:0] sum
// ---------------------------------------------------------------------------
module tut4_verilog_gcd_gcd_client #(
  parameter int p_max_out = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  tut4_verilog_gcd_gcd_client_if.slave        cmd,
  tut4_verilog_gcd_gcd_client_if.master       req,
  tut4_verilog_gcd_gcd_client_if.slave        resp,
  tut4_verilog_gcd_gcd_client_if.master       done
);

  // Three bits are enough to count up to four requests in flight.
  localparam logic [2:0] MaxOut = 3'(p_max_out);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic [7:0]  n_q,     n_d;
  logic [15:0] a_q,     a_d;
  logic [15:0] b_q,     b_d;
  logic [7:0]  sent_q,  sent_d;
  logic [7:0]  recvd_q, recvd_d;
  logic [2:0]  out_q,   out_d;
  logic [15:0] sum_q,   sum_d;

  logic        cmd_rdy;
  logic        req_val;
  logic        resp_rdy;
  logic        done_val;
  logic [31:0] req_msg;
  logic [23:0] done_msg;

  logic        cmd_fire;
  logic        req_fire;
  logic        resp_fire;
  logic        done_fire;

  // State register. Reset drops straight back to IDLE without waiting for
  // a clock edge, which abandons any requests still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. All outputs are Moore (state and
  // counters only), so the fire strobes are formed here from the handshake
  // inputs and the ready/valid values this block has just decided.
  // The DONE transition uses the receive count including a response that
  // fires this cycle, so the summary appears one cycle after the last
  // response. With N = 0 the count already matches and RUN lasts one cycle.
  always_comb begin
    state_d   = state_q;
    cmd_rdy   = 1'b0;
    req_val   = 1'b0;
    resp_rdy  = 1'b0;
    done_val  = 1'b0;
    req_msg   = {a_q, b_q};
    done_msg  = {recvd_q, sum_q};
    cmd_fire  = 1'b0;
    req_fire  = 1'b0;
    resp_fire = 1'b0;
    done_fire = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_rdy  = 1'b1;
        cmd_fire = cmd.val;
        if (cmd_fire) begin
          state_d = RUN;
        end
      end

      RUN: begin
        resp_rdy  = 1'b1;
        req_val   = (sent_q < n_q) && (out_q < MaxOut);
        req_fire  = req_val && req.rdy;
        resp_fire = resp.val;
        if ((recvd_q + 8'(resp_fire)) == n_q) begin
          state_d = DONE;
        end
      end

      DONE: begin
        done_val  = 1'b1;
        done_fire = done.rdy;
        if (done_fire) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = state_e'(2'bxx);
        cmd_rdy   = 1'bx;
        req_val   = 1'bx;
        resp_rdy  = 1'bx;
        done_val  = 1'bx;
        req_msg   = 'x;
        done_msg  = 'x;
        cmd_fire  = 1'bx;
        req_fire  = 1'bx;
        resp_fire = 1'bx;
        done_fire = 1'bx;
      end
    endcase
  end

  // Datapath next-state. A command reloads the operands and clears the
  // bookkeeping. A fired request advances the a operand so that the next
  // request is already sitting in the register, keeping req_msg stable
  // across back-pressure. The outstanding count only moves when exactly
  // one of request/response fires.
  always_comb begin
    n_d     = n_q;
    a_d     = a_q;
    b_d     = b_q;
    sent_d  = sent_q;
    recvd_d = recvd_q;
    out_d   = out_q;
    sum_d   = sum_q;

    if (cmd_fire) begin
      n_d     = cmd.msg[39:32];
      a_d     = cmd.msg[31:16];
      b_d     = cmd.msg[15:0];
      sent_d  = 8'd0;
      recvd_d = 8'd0;
      out_d   = 3'd0;
      sum_d   = 16'd0;
    end

    if (req_fire) begin
      sent_d = sent_q + 8'd1;
      a_d    = a_q + 16'd1;
    end

    if (resp_fire) begin
      recvd_d = recvd_q + 8'd1;
      sum_d   = sum_q + resp.msg;
    end

    case ({req_fire, resp_fire})
      2'b10:   out_d = out_q + 3'd1;
      2'b01:   out_d = out_q - 3'd1;
      default: out_d = out_q;
    endcase
  end

  // Datapath registers, all cleared by reset so that req_msg and done_msg
  // read as zero until the first command arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q     <= 8'd0;
      a_q     <= 16'd0;
      b_q     <= 16'd0;
      sent_q  <= 8'd0;
      recvd_q <= 8'd0;
      out_q   <= 3'd0;
      sum_q   <= 16'd0;
    end else begin
      n_q     <= n_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sent_q  <= sent_d;
      recvd_q <= recvd_d;
      out_q   <= out_d;
      sum_q   <= sum_d;
    end
  end

  assign cmd.rdy  = cmd_rdy;
  assign req.val  = req_val;
  assign req.msg  = req_msg;
  assign resp.rdy = resp_rdy;
  assign done.val = done_val;
  assign done.msg = done_msg;

endmodule

// File: tb/tb_tut4_verilog_gcd_gcd_client.sv
// ---------------------------------------------------------------------------
// tb_tut4_verilog_gcd_gcd_client
//
// Two clients share clock and reset: dut1 allows one request in flight and
// is served by a GCD model answering one cycle after acceptance; dut2
// allows two and is served by a model answering two cycles after
// acceptance. Expected requests and summaries are queued when a command is
// issued and consumed as the clients produce them.
// ---------------------------------------------------------------------------
module tb_tut4_verilog_gcd_gcd_client;

  logic clk;
  logic reset;

  tut4_verilog_gcd_gcd_client_if #(.W(40)) cmd1 ();
  tut4_verilog_gcd_gcd_client_if #(.W(32)) req1 ();
  tut4_verilog_gcd_gcd_client_if #(.W(16)) resp1 ();
  tut4_verilog_gcd_gcd_client_if #(.W(24)) done1 ();

  tut4_verilog_gcd_gcd_client_if #(.W(40)) cmd2 ();
  tut4_verilog_gcd_gcd_client_if #(.W(32)) req2 ();
  tut4_verilog_gcd_gcd_client_if #(.W(16)) resp2 ();
  tut4_verilog_gcd_gcd_client_if #(.W(24)) done2 ();

  tut4_verilog_gcd_gcd_client #(.p_max_out(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd1),
    .req   (req1),
    .resp  (resp1),
    .done  (done1)
  );

  tut4_verilog_gcd_gcd_client #(.p_max_out(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .cmd   (cmd2),
    .req   (req2),
    .resp  (resp2),
    .done  (done2)
  );

  int          checks;
  int          failures;
  logic        reqStall1;
  int          flushReq1;
  logic        concurrent2;

  logic [31:0] expReq1[$];
  logic [31:0] expReq2[$];
  logic [23:0] expDone[$];
  logic [15:0] rqRes1[$];
  int          rqAt1[$];
  logic [15:0] rqRes2[$];
  int          rqAt2[$];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [15:0] gcdModel(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic checkOutput(input string tag, input logic [39:0] observed,
                             input logic [39:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_cmd_rdy"},  cmd1.rdy,  1'b1);
    checkOutput({tag, "_req_val"},  req1.val,  1'b0);
    checkOutput({tag, "_resp_rdy"}, resp1.rdy, 1'b0);
    checkOutput({tag, "_done_val"}, done1.val, 1'b0);
    checkOutput({tag, "_req_msg"},  req1.msg,  32'h0);
    checkOutput({tag, "_done_msg"}, done1.msg, 24'h0);
  endtask

  // Queue the expected requests and summary, then issue the command and
  // return on the first cycle of RUN with cmd_val dropped.
  task automatic applyStimulus(input int d, input logic [7:0] n,
                               input logic [15:0] a0, input logic [15:0] b0);
    logic [15:0] a;
    logic [15:0] sum;
    logic        rdy;
    sum = 16'd0;
    for (int i = 0; i < int'(n); i++) begin
      a = a0 + 16'(i);
      if (d == 0) expReq1.push_back({a, b0});
      else        expReq2.push_back({a, b0});
      sum = sum + gcdModel(a, b0);
    end
    expDone.push_back({n, sum});
    for (int k = 0; k < 50; k++) begin
      rdy = (d == 0) ? cmd1.rdy : cmd2.rdy;
      if (rdy) break;
      @(negedge clk);
    end
    rdy = (d == 0) ? cmd1.rdy : cmd2.rdy;
    checkOutput("cmd_rdy_idle", rdy, 1'b1);
    if (d == 0) begin
      cmd1.val = 1'b1;
      cmd1.msg = {n, a0, b0};
    end else begin
      cmd2.val = 1'b1;
      cmd2.msg = {n, a0, b0};
    end
    @(negedge clk);
    if (d == 0) begin
      cmd1.val = 1'b0;
      checkOutput("cmd_rdy_run", cmd1.rdy, 1'b0);
      checkOutput("req_val_first", req1.val, n != 8'd0);
    end else begin
      cmd2.val = 1'b0;
      checkOutput("cmd_rdy_run2", cmd2.rdy, 1'b0);
      checkOutput("req_val_first2", req2.val, n != 8'd0);
    end
  endtask

  // Wait (bounded) for the summary and compare it with the queued one.
  task automatic waitDone(input int d, output logic [23:0] expMsg);
    logic val;
    for (int k = 0; k < 300; k++) begin
      val = (d == 0) ? done1.val : done2.val;
      if (val) break;
      @(negedge clk);
    end
    val = (d == 0) ? done1.val : done2.val;
    checkOutput("done_val", val, 1'b1);
    expMsg = (expDone.size() > 0) ? expDone.pop_front() : 24'hxxxxxx;
    checkOutput("done_msg", (d == 0) ? done1.msg : done2.msg, expMsg);
  endtask

  task automatic finishDone(input int d);
    if (d == 0) done1.rdy = 1'b1;
    else        done2.rdy = 1'b1;
    @(negedge clk);
    if (d == 0) begin
      done1.rdy = 1'b0;
      checkOutput("idle_cmd_rdy", cmd1.rdy, 1'b1);
      checkOutput("idle_done_val", done1.val, 1'b0);
    end else begin
      done2.rdy = 1'b0;
      checkOutput("idle_cmd_rdy2", cmd2.rdy, 1'b1);
      checkOutput("idle_done_val2", done2.val, 1'b0);
    end
  endtask

  // GCD unit model for dut1: drives just after the falling edge, samples
  // the handshakes just before the rising edge. Responses become valid one
  // cycle after the request is accepted.
  initial begin : responder1
    int          tick;
    int          seen;
    logic        prevReqF;
    logic        prevRespF;
    logic        reqF;
    logic        respF;
    logic [31:0] expMsg;
    tick = 0;
    seen = 0;
    prevReqF = 1'b0;
    prevRespF = 1'b0;
    req1.rdy = 1'b0;
    resp1.val = 1'b0;
    resp1.msg = 16'h0;
    forever begin
      @(negedge clk);
      #1;
      tick++;
      if (seen != flushReq1) begin
        rqRes1.delete();
        rqAt1.delete();
        seen = flushReq1;
      end
      if (prevReqF) checkOutput("req_drop", req1.val, 1'b0);
      if (prevRespF) checkOutput("req_reassert", req1.val, expReq1.size() != 0);
      req1.rdy = !reqStall1;
      resp1.val = 1'b0;
      resp1.msg = 16'h0;
      if (rqRes1.size() > 0) begin
        resp1.msg = rqRes1[0];
        resp1.val = (rqAt1[0] <= tick);
      end
      #3;
      respF = resp1.val && resp1.rdy;
      reqF = req1.val && req1.rdy;
      if (respF) begin
        void'(rqRes1.pop_front());
        void'(rqAt1.pop_front());
      end
      if (reqF) begin
        expMsg = (expReq1.size() > 0) ? expReq1.pop_front() : 32'hxxxxxxxx;
        checkOutput("req_msg", req1.msg, expMsg);
        rqRes1.push_back(gcdModel(req1.msg[31:16], req1.msg[15:0]));
        rqAt1.push_back(tick + 1);
        checkOutput("outstanding_max1", rqRes1.size() <= 1, 1'b1);
      end
      prevReqF = reqF;
      prevRespF = respF;
    end
  end

  // GCD unit model for dut2: responses become valid two cycles after
  // acceptance, so two requests are taken before the first answer.
  initial begin : responder2
    int          tick;
    logic        reqF;
    logic        respF;
    logic [31:0] expMsg;
    tick = 0;
    concurrent2 = 1'b0;
    req2.rdy = 1'b0;
    resp2.val = 1'b0;
    resp2.msg = 16'h0;
    forever begin
      @(negedge clk);
      #1;
      tick++;
      req2.rdy = 1'b1;
      resp2.val = 1'b0;
      resp2.msg = 16'h0;
      if (rqRes2.size() > 0) begin
        resp2.msg = rqRes2[0];
        resp2.val = (rqAt2[0] <= tick);
      end
      #3;
      respF = resp2.val && resp2.rdy;
      reqF = req2.val && req2.rdy;
      if (reqF && respF) concurrent2 = 1'b1;
      if (respF) begin
        void'(rqRes2.pop_front());
        void'(rqAt2.pop_front());
      end
      if (reqF) begin
        expMsg = (expReq2.size() > 0) ? expReq2.pop_front() : 32'hxxxxxxxx;
        checkOutput("req_msg2", req2.msg, expMsg);
        rqRes2.push_back(gcdModel(req2.msg[31:16], req2.msg[15:0]));
        rqAt2.push_back(tick + 2);
        checkOutput("outstanding_max2", rqRes2.size() <= 2, 1'b1);
      end
    end
  end

  // Directed sequence.
  initial begin : mainSeq
    logic [23:0] expMsg;
    checks = 0;
    failures = 0;
    reset = 1'b0;
    reqStall1 = 1'b0;
    flushReq1 = 0;
    cmd1.val = 1'b0;
    cmd1.msg = 40'h0;
    done1.rdy = 1'b0;
    cmd2.val = 1'b0;
    cmd2.msg = 40'h0;
    done2.rdy = 1'b0;

    // Reset values before any clock edge, and after release.
    #2;
    checkResetOutputs("reset_async");
    checkOutput("reset_cmd_rdy2", cmd2.rdy, 1'b1);
    checkOutput("reset_done_msg2", done2.msg, 24'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetOutputs("reset_release");

    // Basic run: N=3, a0=12, b0=8.
    applyStimulus(0, 8'd3, 16'd12, 16'd8);
    waitDone(0, expMsg);
    finishDone(0);

    // N=0: no requests, summary two cycles after the command.
    applyStimulus(0, 8'd0, 16'd5, 16'd7);
    checkOutput("n0_done_early", done1.val, 1'b0);
    @(negedge clk);
    checkOutput("n0_done_val", done1.val, 1'b1);
    checkOutput("n0_done_msg", done1.msg, 24'h000000);
    waitDone(0, expMsg);
    finishDone(0);

    // Wrapping operand with the request side stalled for five cycles.
    reqStall1 = 1'b1;
    applyStimulus(0, 8'd2, 16'hffff, 16'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("stall_req_val", req1.val, 1'b1);
      checkOutput("stall_req_msg", req1.msg, 32'hffff0001);
    end
    reqStall1 = 1'b0;
    waitDone(0, expMsg);
    finishDone(0);

    // Summary held under back-pressure, then back-to-back command.
    applyStimulus(0, 8'd1, 16'd10, 16'd4);
    waitDone(0, expMsg);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("hold_done_val", done1.val, 1'b1);
      checkOutput("hold_done_msg", done1.msg, expMsg);
      checkOutput("hold_cmd_rdy", cmd1.rdy, 1'b0);
    end
    finishDone(0);
    applyStimulus(0, 8'd2, 16'd100, 16'd75);
    waitDone(0, expMsg);
    finishDone(0);

    // Reset pulse between edges in the middle of a run.
    applyStimulus(0, 8'd3, 16'd20, 16'd15);
    @(negedge clk);
    checkOutput("pre_reset_resp_rdy", resp1.rdy, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkResetOutputs("reset_mid_run");
    reset = 1'b1;
    expReq1.delete();
    expDone.delete();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("stray_cmd_rdy", cmd1.rdy, 1'b1);
      checkOutput("stray_resp_rdy", resp1.rdy, 1'b0);
      checkOutput("stray_done_val", done1.val, 1'b0);
      checkOutput("stray_req_val", req1.val, 1'b0);
    end
    flushReq1++;
    @(negedge clk);
    applyStimulus(0, 8'd1, 16'd9, 16'd6);
    waitDone(0, expMsg);
    finishDone(0);

    // Two in flight with overlapping request/response.
    applyStimulus(1, 8'd4, 16'd6, 16'd3);
    waitDone(1, expMsg);
    finishDone(1);
    checkOutput("concurrent_fire", concurrent2, 1'b1);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
